// File: rtl/vec_mem_stage.sv
// Vector load/store stage: spreads 16 lanes over 16 word-interleaved banks, serialising bank collisions.
// Latency: load wb_valid at accept+N+2, store st_done at accept+N+1 (N = worst lanes per bank).
// Backpressure: in_ready high only in IDLE; no stall from the banks (fixed 1-cycle read latency).
module vec_mem_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_isVld,
  input  logic         in_isVst,
  input  logic [15:0]  in_base,
  input  logic [15:0]  in_stride,
  input  logic [3:0]   in_vt,
  input  logic [255:0] in_vdata,
  output logic [175:0] bank_raddr,
  input  logic [255:0] bank_rdata,
  output logic [15:0]  bank_wen,
  output logic [175:0] bank_waddr,
  output logic [255:0] bank_wdata,
  output logic         wb_valid,
  output logic [3:0]   wb_vt,
  output logic [255:0] wb_data,
  output logic         st_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic           is_vld_q, is_vld_d;
  logic [3:0]     vt_q, vt_d;
  logic [255:0]   vdata_q, vdata_d;
  logic [239:0]   addr_q, addr_d;     // 16 lane word addresses, 15 bits each
  logic [15:0]    mask_q, mask_d;     // lanes still waiting for their bank
  logic [15:0]    cap_q, cap_d;       // load lanes whose read data arrives this cycle
  logic [255:0]   wb_data_q, wb_data_d;

  logic [15:0]    issue;
  logic [15:0]    taken;
  logic [3:0]     arb_bank;
  logic [10:0]    arb_row;
  logic [175:0]   raddr_c;
  logic [15:0]    wen_c;
  logic [175:0]   waddr_c;
  logic [255:0]   wdata_c;

  // Byte-address bit 0 and stride bit 15 have no effect on word addressing.
  logic unused_bits;
  assign unused_bits = in_base[0] ^ in_stride[15];

  // Per-bank arbitration: ascending lane scan gives each bank its lowest pending lane.
  always_comb begin
    issue    = '0;
    taken    = '0;
    arb_bank = '0;
    arb_row  = '0;
    raddr_c  = '0;
    wen_c    = '0;
    waddr_c  = '0;
    wdata_c  = '0;
    for (int i = 0; i < 16; i++) begin
      arb_bank = addr_q[15*i +: 4];
      arb_row  = addr_q[15*i+4 +: 11];
      if (state_q == ISSUE && mask_q[i] && !taken[arb_bank]) begin
        taken[arb_bank] = 1'b1;
        issue[i]        = 1'b1;
        if (is_vld_q) begin
          raddr_c[11*arb_bank +: 11] = arb_row;
        end else begin
          wen_c[arb_bank]             = 1'b1;
          waddr_c[11*arb_bank +: 11]  = arb_row;
          wdata_c[16*arb_bank +: 16]  = vdata_q[16*i +: 16];
        end
      end
    end
  end

  // Next-state, operand latch, lane retirement and load-data capture.
  always_comb begin
    state_d   = state_q;
    is_vld_d  = is_vld_q;
    vt_d      = vt_q;
    vdata_d   = vdata_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    cap_d     = '0;
    wb_data_d = wb_data_q;
    for (int i = 0; i < 16; i++) begin
      if (cap_q[i]) begin
        wb_data_d[16*i +: 16] = bank_rdata[16*addr_q[15*i +: 4] +: 16];
      end
    end
    case (state_q)
      IDLE: begin
        // Illegal type encodings are consumed here without leaving IDLE.
        if (in_valid && (in_isVld ^ in_isVst)) begin
          state_d  = ISSUE;
          is_vld_d = in_isVld;
          vt_d     = in_vt;
          vdata_d  = in_vdata;
          mask_d   = 16'hFFFF;
          for (int i = 0; i < 16; i++) begin
            addr_d[15*i +: 15] = in_base[15:1] + in_stride[14:0] * 15'(i);
          end
        end
      end
      ISSUE: begin
        mask_d = mask_q & ~issue;
        cap_d  = is_vld_q ? issue : 16'h0000;
        if (mask_d == 16'h0000) begin
          state_d = is_vld_q ? DRAIN : DONE;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_vld_q  <= 1'b0;
      vt_q      <= '0;
      vdata_q   <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      cap_q     <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      is_vld_q  <= is_vld_d;
      vt_q      <= vt_d;
      vdata_q   <= vdata_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Outputs are suppressed while rst is high so a reset cycle never writes a bank or pulses.
  assign in_ready   = (state_q == IDLE);
  assign bank_raddr = rst ? '0 : raddr_c;
  assign bank_wen   = rst ? '0 : wen_c;
  assign bank_waddr = rst ? '0 : waddr_c;
  assign bank_wdata = rst ? '0 : wdata_c;
  assign wb_valid   = !rst && (state_q == DONE) && is_vld_q;
  assign st_done    = !rst && (state_q == DONE) && !is_vld_q;
  assign wb_vt      = vt_q;
  assign wb_data    = wb_data_q;

endmodule

// File: doc/vec_mem_stage.md
# vec_mem_stage

Vector memory stage directly downstream of decode/execute. Accepts one decoded vector load (VLD) or vector store (VST) per handshake and spreads its sixteen 16-bit lanes across the 16 word-interleaved data banks (mem_bank0..15). Serialises lanes that collide on the same bank. For loads, assembles the 256-bit result and presents it for write into the vector register file (vregs).

## Interface
- No parameters; lanes = 16, lane width = 16, banks = 16, bank row width = 11 (fixed).
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded vector memory op present.
- in_ready  out  1  stage can accept; high only in IDLE.
- in_isVld  in  1  op is a vector load.
- in_isVst  in  1  op is a vector store; both low or both high while in_valid is illegal and the op is dropped.
- in_base  in  16  byte base address; bit 0 is ignored.
- in_stride  in  16  lane stride in 16-bit words, unsigned, mod 2^15.
- in_vt  in  4  destination vreg for VLD.
- in_vdata  in  256  store data; lane i = bits [16i+15:16i].
- bank_raddr  out  16x11  per-bank read row, flattened; bank b = [11b+10:11b].
- bank_rdata  in  16x16  per-bank read data, valid the cycle after the address.
- bank_wen  out  16  per-bank write enable.
- bank_waddr  out  16x11  per-bank write row.
- bank_wdata  out  16x16  per-bank write data.
- wb_valid  out  1  one-cycle pulse: wb_vt/wb_data valid for vreg write.
- wb_vt  out  4  destination vreg.
- wb_data  out  256  assembled load vector.
- st_done  out  1  one-cycle pulse: all store lanes written.

## Operation
- Lane i word address A_i = (in_base[15:1] + i*in_stride) mod 2^15. Bank = A_i[3:0]; row = A_i[14:4].
- Accept when in_valid && in_ready. Latch op type, vt, store data, the 16 lane addresses, and pending mask = 16'hFFFF.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE on accept.
- ISSUE, each cycle: for every bank, pick the lowest-numbered pending lane mapped to it. Drive its row on bank_raddr (load) or bank_wen/waddr/wdata (store). Clear those lanes from the mask.
- Load data: the lanes issued in cycle k are captured from bank_rdata into wb_data lane slots in cycle k+1. This capture overlaps the next issue.
- ISSUE exits when the mask becomes empty: to DRAIN for loads, to DONE for stores.
- DRAIN: capture the last issued lanes, then go to DONE.
- DONE, load: wb_valid = 1 with wb_vt and the full wb_data. DONE, store: st_done = 1. DONE -> IDLE unconditionally.
- Stores to one bank in a single cycle are impossible by construction. Same-address lanes (e.g. stride 0, or stride a multiple of 2^15) are written in ascending lane order, so the highest lane wins.
- Loads with repeated addresses read each lane separately; every lane gets the same value.
- An illegal op (both type bits high or both low) is accepted and discarded: the FSM stays IDLE, with no bank activity and no pulse.
- Unused banks in a cycle: bank_wen = 0, addr/data = 0.

## Timing
- Reset values: state IDLE, in_ready = 1, mask = 0, bank_wen = 0, all bank_raddr/waddr/wdata = 0, wb_valid = 0, wb_vt = 0, wb_data = 0, st_done = 0.
- Notation: accept in cycle T. N = max lanes mapped to any one bank (1..16).
- Load: issue cycles T+1..T+N, DRAIN at T+N+1, wb_valid at T+N+2, in_ready high again at T+N+3.
- Store: writes at T+1..T+N, st_done at T+N+1, in_ready high at T+N+2.
- Examples of N:
  - Unit stride, any alignment: N = 1 (load wb_valid at T+3).
  - Stride 2: N = 2.
  - Stride 16 or stride 0: N = 16.
- in_ready is low from T+1 until return to IDLE; inputs are ignored while it is low.
- Addresses wrap mod 2^15 words without error. A wrapped lane maps to its normal bank/row.
- rst mid-operation: returns to IDLE next edge and clears the mask. No further bank writes occur; store lanes already written stay written. No wb_valid/st_done pulse is emitted.
- wb_data holds its last value outside wb_valid.

## Test plan
- Reset: hold rst 2 cycles -> all outputs at reset values, in_ready = 1, bank_wen = 0.
- Unit-stride VLD: base = 0x0006 (word 3), stride 1, vt = 5, bank contents set so each bank returns its bank number. Required response:
  - Cycle T+1: bank 3 row 0 serves lane 0, bank 2 row 1 serves lane 15.
  - Cycle T+3: wb_valid = 1, wb_vt = 5, wb_data lane i = (3+i)&15.
- Stride-2 VST: base = 0, data lane i = 0x1000+i. Required response:
  - T+1: lanes 0..7 written to banks 0,2,..14, row 0.
  - T+2: lanes 8..15 written to the same banks, row 1.
  - T+3: st_done = 1.
- Stride-0 VST: base = 0x0020, lane i = i -> bank 0 row 1 written 16 times at T+1..T+16, final value 0x000F, st_done at T+17.
- Wrap-around VLD: base = 0xFFFC (word 0x7FFE), stride 1.
  - Lanes 0,1 read banks 14,15 at row 0x7FF.
  - Lanes 2..15 read banks 0..13 at row 0.
  - wb_valid at T+3.
- Reset mid-store: stride 16, assert rst at T+5 -> only lanes 0..3 written (T+1..T+4). Next cycle in IDLE with in_ready = 1; no st_done pulse. A following unit-stride VLD completes normally at +3.
